imul_pipe: RTL and testbench
============================

IMUL_PIPE -- requirements
Module: imul_pipe

Interface
REQ-001 Parameter W, default 64, operand/result width; legal values 32 or 64.
REQ-002 Parameter STAGES, default 3, accept-to-result latency in cycles; legal range 2..4.
REQ-003 Parameter TAGW, default 6, width of the opaque tag carried with each operation.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 in_vld  input  1  operation present on op/a/b/tag.
REQ-007 in_rdy  output  1  block accepts the operation this cycle.
REQ-008 op  input  3  operation code (package enum).
REQ-009 a, b  input  W each  multiplicand and multiplier.
REQ-010 tag  input  TAGW  returned unchanged with the result.
REQ-011 flush  input  1  discard all in-flight operations.
REQ-012 out_vld  output  1  result valid.
REQ-013 out_rdy  input  1  consumer takes the result this cycle.
REQ-014 res  output  W  result.
REQ-015 out_tag  output  TAGW  tag of the result.
REQ-016 flg  output  6  {C,O,0,S,Z,P}; present only under IMUL_PIPE_FLAGS_EN.

Function
REQ-017 Ops: MUL_LO low W bits of the product; MULH_UU, MULH_SS and MULH_SU return the high W bits with unsigned/unsigned, signed/signed and signed-a/unsigned-b interpretation; MUL_HALF returns the unsigned (W/2)x(W/2) product zero-extended; IMUL_HALF returns the signed (W/2)x(W/2) low W/2 bits sign-extended to W; codes 6-7 return 0.
REQ-018 The full 2W-bit product is computed for every op; the op selects the bits returned.
REQ-019 Acceptance is in_vld && in_rdy; in_rdy = !out_vld || out_rdy (global stall).
REQ-020 Without stall, out_vld rises exactly STAGES cycles after acceptance; one operation per cycle is sustained.
REQ-021 While out_vld && !out_rdy, every stage holds its contents and res/out_tag/flg stay stable.
REQ-022 Results leave in acceptance order; each carries its own tag.
REQ-023 flush clears every stage valid bit at the next edge; an operation presented in the flush cycle is dropped; out_vld is 0 in the following cycle.
REQ-024 flush overrides a simultaneous stall.
REQ-025 Flags: C=O=1 when the returned result, extended per its signedness, differs from the full product (truncation lost information); S=res MSB; Z=(res==0); P=even parity of res[7:0]; bit 3 is 0.
REQ-026 For MULH_* ops, C=O=(low W bits != 0) and Z reflects the full 2W-bit product.

Reset
REQ-027 When rst=0 at an edge: all stage valid bits are 0, out_vld=0, res=0, out_tag=0, flg=0; in_rdy=1 in the following cycle.
REQ-028 Reset mid-operation discards all in-flight operations; no result is emitted afterwards for them.
REQ-029 Datapath registers other than output registers need no reset.

Configuration
REQ-030 Macro IMUL_PIPE_FLAGS_EN: when defined, flag logic and the flg port exist per REQ-025/026; when undefined, the flg port and its pipeline bits are absent and all other behaviour is identical.

Structure
REQ-031 The shared package holds the op enum (MUL_LO=0, MULH_UU=1, MULH_SS=2, MULH_SU=3, MUL_HALF=4, IMUL_HALF=5), the flag bit indices, and the STAGES legality constants.
REQ-032 One sub-module, imul_pipe_stage, is a generic stall-able register slice (valid, payload, enable, flush); it is instantiated STAGES times with partial-product reduction split between slices.

Verification (W=64, STAGES=3)
REQ-033 MULH_SS a=b=0xFFFF_FFFF_FFFF_FFFF -> res=0, C=O=1, Z=0, out_vld at cycle 3 after acceptance.
REQ-034 MULH_UU a=b=0xFFFF_FFFF_FFFF_FFFF -> res=0xFFFF_FFFF_FFFF_FFFE; MUL_LO on the same operands -> res=1, C=O=1.
REQ-035 IMUL_HALF a=0x8000_0000, b=2 -> res=0, C=O=1, Z=1; MUL_HALF on the same operands -> res=0x1_0000_0000, C=O=0.
REQ-036 Back-to-back accepts of tags 1..5 with out_rdy=0 for cycles 4-6 -> in_rdy=0 during the stall, results appear in tag order 1..5, none lost or duplicated.
REQ-037 flush asserted with three operations in flight plus one presented -> out_vld=0 for the next 4 cycles; the next accepted operation (tag 9) is returned alone.
REQ-038 rst=0 for one cycle mid-stream -> out_vld=0 and res=0 in the following cycle; no stale results afterwards.

Source files
------------

// File: rtl/imul_pipe_pkg.sv
// Shared definitions for the imul_pipe multiplier: op codes, flag bit positions,
// legal pipeline depth range and a parity helper.
package imul_pipe_pkg;

  typedef enum logic [2:0] {
    MUL_LO    = 3'd0,
    MULH_UU   = 3'd1,
    MULH_SS   = 3'd2,
    MULH_SU   = 3'd3,
    MUL_HALF  = 3'd4,
    IMUL_HALF = 3'd5
  } op_e;

  // Flag vector layout {C,O,0,S,Z,P}
  localparam int FLG_W   = 6;
  localparam int FLG_C   = 5;
  localparam int FLG_O   = 4;
  localparam int FLG_RSV = 3;
  localparam int FLG_S   = 2;
  localparam int FLG_Z   = 1;
  localparam int FLG_P   = 0;

  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;

  function automatic logic even_parity(input logic [7:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/imul_pipe_stage.sv
// Generic stall-able register slice: valid bit plus payload, global enable,
// flush clears the valid bit regardless of enable.
module imul_pipe_stage #(
  parameter int DW       = 8,
  parameter bit RST_DATA = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_flush,
  input  logic          i_vld,
  input  logic [DW-1:0] i_data,
  output logic          o_vld,
  output logic [DW-1:0] o_data
);

  logic          r_vld;
  logic [DW-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_vld <= 1'b0;
    end else if (i_flush) begin
      r_vld <= 1'b0;
    end else if (i_en) begin
      r_vld <= i_vld;
    end
  end

  // Only slices that drive module outputs carry a payload reset.
  if (RST_DATA) begin : g_rst_data
    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        r_data <= '0;
      end else if (i_en) begin
        r_data <= i_data;
      end
    end
  end else begin : g_no_rst_data
    always_ff @(posedge i_clk) begin
      if (i_en) begin
        r_data <= i_data;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_data = r_data;

endmodule

// File: rtl/imul_pipe.sv
// Pipelined integer multiplier with tag passthrough, global stall and flush.
// Optional flag output enabled by defining IMUL_PIPE_FLAGS_EN.
module imul_pipe
  import imul_pipe_pkg::*;
#(
  parameter int W      = 64,
  parameter int STAGES = 3,
  parameter int TAGW   = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [2:0]      op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [TAGW-1:0] tag,
  input  logic            flush,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [W-1:0]    res,
  output logic [TAGW-1:0] out_tag
`ifdef IMUL_PIPE_FLAGS_EN
  ,
  output logic [FLG_W-1:0] flg
`endif
);

  localparam int H  = W / 2;
  localparam int NS = (STAGES < STAGES_MIN) ? STAGES_MIN :
                      (STAGES > STAGES_MAX) ? STAGES_MAX : STAGES;
  // Placement of the partial-product and reduction steps across the slices;
  // the final slice always performs result selection.
  localparam int PP_IDX  = (NS == STAGES_MAX) ? 1 : 0;
  localparam int SUM_IDX = (NS == STAGES_MIN) ? 1 : NS - 2;

  typedef struct packed {
    logic [2:0]      op;
    logic [TAGW-1:0] tag;
    logic            sa;
    logic            sb;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [W-1:0]    pp0;
    logic [W-1:0]    pp1;
    logic [W-1:0]    pp2;
    logic [W-1:0]    pp3;
    logic [2*W-1:0]  prod;
  } mid_t;

  typedef struct packed {
    logic [W-1:0]     res;
    logic [TAGW-1:0]  tag;
`ifdef IMUL_PIPE_FLAGS_EN
    logic [FLG_W-1:0] flg;
`endif
  } out_t;

  // Operand conditioning for half-width ops, then four unsigned half products.
  function automatic mid_t f_pp(input mid_t m);
    mid_t         x;
    logic [H-1:0] alo;
    logic [H-1:0] blo;
    x   = m;
    alo = m.a[H-1:0];
    blo = m.b[H-1:0];
    x.sa = 1'b0;
    x.sb = 1'b0;
    case (m.op)
      MULH_SS: begin
        x.sa = 1'b1;
        x.sb = 1'b1;
      end
      MULH_SU: x.sa = 1'b1;
      MUL_HALF: begin
        x.a = {{(W-H){1'b0}}, alo};
        x.b = {{(W-H){1'b0}}, blo};
      end
      IMUL_HALF: begin
        x.a  = {{(W-H){alo[H-1]}}, alo};
        x.b  = {{(W-H){blo[H-1]}}, blo};
        x.sa = 1'b1;
        x.sb = 1'b1;
      end
      default: ;
    endcase
    x.pp0 = {{H{1'b0}}, x.a[H-1:0]} * {{H{1'b0}}, x.b[H-1:0]};
    x.pp1 = {{H{1'b0}}, x.a[H-1:0]} * {{H{1'b0}}, x.b[W-1:H]};
    x.pp2 = {{H{1'b0}}, x.a[W-1:H]} * {{H{1'b0}}, x.b[H-1:0]};
    x.pp3 = {{H{1'b0}}, x.a[W-1:H]} * {{H{1'b0}}, x.b[W-1:H]};
    return x;
  endfunction

  // Unsigned sum of partial products; a negative signed operand contributes
  // -(other operand << W) modulo 2^(2W).
  function automatic mid_t f_sum(input mid_t m);
    mid_t           x;
    logic [2*W-1:0] p;
    x = m;
    p = {m.pp3, m.pp0}
      + {{H{1'b0}}, m.pp1, {H{1'b0}}}
      + {{H{1'b0}}, m.pp2, {H{1'b0}}};
    if (m.sa && m.a[W-1]) p = p - {m.b, {W{1'b0}}};
    if (m.sb && m.b[W-1]) p = p - {m.a, {W{1'b0}}};
    x.prod = p;
    return x;
  endfunction

  function automatic out_t f_sel(input mid_t m);
    out_t         o;
    logic [W-1:0] r;
`ifdef IMUL_PIPE_FLAGS_EN
    logic         lost;
    logic         hi_op;
`endif
    case (m.op)
      MUL_LO, MUL_HALF:          r = m.prod[W-1:0];
      MULH_UU, MULH_SS, MULH_SU: r = m.prod[2*W-1:W];
      IMUL_HALF:                 r = {{(W-H){m.prod[H-1]}}, m.prod[H-1:0]};
      default:                   r = '0;
    endcase
`ifdef IMUL_PIPE_FLAGS_EN
    hi_op = 1'b0;
    case (m.op)
      MUL_LO, MUL_HALF: lost = |m.prod[2*W-1:W];
      MULH_UU, MULH_SS, MULH_SU: begin
        lost  = |m.prod[W-1:0];
        hi_op = 1'b1;
      end
      IMUL_HALF: lost = ({{(2*W-H){m.prod[H-1]}}, m.prod[H-1:0]} != m.prod);
      default:   lost = 1'b0;
    endcase
    o.flg          = '0;
    o.flg[FLG_C]   = lost;
    o.flg[FLG_O]   = lost;
    o.flg[FLG_RSV] = 1'b0;
    o.flg[FLG_S]   = r[W-1];
    o.flg[FLG_Z]   = hi_op ? (m.prod == '0) : (r == '0);
    o.flg[FLG_P]   = even_parity(r[7:0]);
`endif
    o.res = r;
    o.tag = m.tag;
    return o;
  endfunction

  logic [NS-1:0] w_vld;
  mid_t          w_mid_q [NS-1];
  out_t          w_out_q;
  logic          w_en;

  // Handshake: an op is taken when in_vld && in_rdy; a result is taken when
  // out_vld && out_rdy. Any unconsumed result freezes every slice at once.
  assign in_rdy = !w_vld[NS-1] || out_rdy;
  assign w_en   = in_rdy;

  for (genvar i = 0; i < NS; i++) begin : g_slice
    mid_t w_src;
    mid_t w_x;
    logic w_vin;

    if (i == 0) begin : g_head
      always_comb begin
        w_src     = '0;
        w_src.op  = op;
        w_src.tag = tag;
        w_src.a   = a;
        w_src.b   = b;
      end
      assign w_vin = in_vld;
    end else begin : g_body
      assign w_src = w_mid_q[i-1];
      assign w_vin = w_vld[i-1];
    end

    always_comb begin
      w_x = w_src;
      if (i == PP_IDX)  w_x = f_pp(w_x);
      if (i == SUM_IDX) w_x = f_sum(w_x);
    end

    if (i < NS - 1) begin : g_mid
      imul_pipe_stage #(
        .DW       ($bits(mid_t)),
        .RST_DATA (1'b0)
      ) u_stage (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (w_en),
        .i_flush (flush),
        .i_vld   (w_vin),
        .i_data  (w_x),
        .o_vld   (w_vld[i]),
        .o_data  (w_mid_q[i])
      );
    end else begin : g_tail
      out_t w_o;
      assign w_o = f_sel(w_x);
      imul_pipe_stage #(
        .DW       ($bits(out_t)),
        .RST_DATA (1'b1)
      ) u_stage (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (w_en),
        .i_flush (flush),
        .i_vld   (w_vin),
        .i_data  (w_o),
        .o_vld   (w_vld[i]),
        .o_data  (w_out_q)
      );
    end
  end

  assign out_vld = w_vld[NS-1];
  assign res     = w_out_q.res;
  assign out_tag = w_out_q.tag;
`ifdef IMUL_PIPE_FLAGS_EN
  assign flg     = w_out_q.flg;
`endif

endmodule

// File: tb/tb_imul_pipe.sv
// Scoreboard bench for imul_pipe (W=64, STAGES=3): directed vectors, stall,
// flush and mid-stream reset; flags are compared when IMUL_PIPE_FLAGS_EN is set.
module tb_imul_pipe;
  import imul_pipe_pkg::*;

  localparam int W      = 64;
  localparam int STAGES = 3;
  localparam int TAGW   = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_vld;
  logic            in_rdy;
  logic [2:0]      op;
  logic [W-1:0]    a;
  logic [W-1:0]    b;
  logic [TAGW-1:0] tag;
  logic            flush;
  logic            out_vld;
  logic            out_rdy;
  logic [W-1:0]    res;
  logic [TAGW-1:0] out_tag;
`ifdef IMUL_PIPE_FLAGS_EN
  logic [5:0]      flg;
`endif

  typedef struct {
    logic [W-1:0]    res;
    logic [TAGW-1:0] tag;
    logic [5:0]      flg;
    bit              lat;
    int              acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  imul_pipe #(.W(W), .STAGES(STAGES), .TAGW(TAGW)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .op      (op),
    .a       (a),
    .b       (b),
    .tag     (tag),
    .flush   (flush),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .res     (res),
    .out_tag (out_tag)
`ifdef IMUL_PIPE_FLAGS_EN
    ,
    .flg     (flg)
`endif
  );

  // clock / reset infrastructure
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver: hold the op until in_rdy, push its expectation at acceptance
  task automatic send(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                      input logic [TAGW-1:0] t, input logic [W-1:0] er, input logic [5:0] ef,
                      input bit exp_en, input bit lat);
    exp_t e;
    int   n;
    op = o; a = va; b = vb; tag = t; in_vld = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_rdy stayed 0 for tag %0d, required 1 within 100 cycles", t);
    end
    if (exp_en) begin
      e.res = er; e.tag = t; e.flg = ef; e.lat = lat; e.acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 in_vld = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 64 && exp_q.size() != 0; n++) @(negedge clk);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst && out_vld && out_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: tag %0d res 0x%0h, required no output", out_tag, res);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res", res, e.res);
        check("tag", 64'(out_tag), 64'(e.tag));
`ifdef IMUL_PIPE_FLAGS_EN
        check("flg", 64'(flg), 64'(e.flg));
`endif
        if (e.lat) check("latency", 64'(cyc - e.acc), 64'(STAGES));
      end
    end
  end

  initial begin
    rst = 1'b0; in_vld = 1'b0; op = '0; a = '0; b = '0; tag = '0;
    flush = 1'b0; out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_vld", 64'(out_vld), 64'd0);
    check("rst_res", res, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_rdy", 64'(in_rdy), 64'd1);
`ifdef IMUL_PIPE_FLAGS_EN
    check("rst_flg", 64'(flg), 64'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b1;

    // directed vectors, back-to-back, fixed latency
    send(MULH_SS, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd1, 64'h0, 6'b110001, 1, 1);
    send(MULH_UU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd2, 64'hFFFF_FFFF_FFFF_FFFE, 6'b110100, 1, 1);
    send(MUL_LO, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd3, 64'h1, 6'b110000, 1, 1);
    send(IMUL_HALF, 64'h8000_0000, 64'h2, 6'd4, 64'h0, 6'b110011, 1, 1);
    send(MUL_HALF, 64'h8000_0000, 64'h2, 6'd5, 64'h1_0000_0000, 6'b000001, 1, 1);
    send(MULH_SU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd6, 64'hFFFF_FFFF_FFFF_FFFF, 6'b110101, 1, 1);
    send(MULH_SS, 64'hFFFF_FFFF_FFFF_FFFE, 64'h3, 6'd7, 64'hFFFF_FFFF_FFFF_FFFF, 6'b110101, 1, 1);
    send(IMUL_HALF, 64'h1234_5678_FFFF_FFFF, 64'h3, 6'd8, 64'hFFFF_FFFF_FFFF_FFFD, 6'b000100, 1, 1);
    send(MUL_HALF, 64'hDEAD_BEEF_FFFF_FFFF, 64'hFFFF_FFFF, 6'd9, 64'hFFFF_FFFE_0000_0001, 6'b000100, 1, 1);
    send(3'd6, 64'h5, 64'h7, 6'd10, 64'h0, 6'b000011, 1, 1);
    send(MULH_UU, 64'h0, 64'h5, 6'd11, 64'h0, 6'b000011, 1, 1);
    send(MULH_UU, 64'h2, 64'h8000_0000_0000_0000, 6'd12, 64'h1, 6'b000000, 1, 1);
    send(3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd13, 64'h0, 6'b000011, 1, 1);
    drain();

    // stall: out_rdy low in cycles 4..6 after the first accept
    fork
      begin
        send(MUL_LO, 64'h10, 64'h3, 6'd1, 64'h30, 6'b000001, 1, 0);
        send(MUL_LO, 64'h123, 64'h10, 6'd2, 64'h1230, 6'b000001, 1, 0);
        send(MUL_LO, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 6'd3, 64'hFFFF_FFFE_0000_0001, 6'b000100, 1, 0);
        send(MUL_LO, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5, 6'd4, 64'hFFFF_FFFF_FFFF_FFFB, 6'b110100, 1, 0);
        send(MUL_LO, 64'h1_0000_0000, 64'h1_0000_0000, 6'd5, 64'h0, 6'b110011, 1, 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_rdy = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("stall_in_rdy", 64'(in_rdy), 64'd0);
          check("stall_out_vld", 64'(out_vld), 64'd1);
          check("stall_res_hold", res, 64'h1230);
          check("stall_tag_hold", 64'(out_tag), 64'd2);
        end
        @(posedge clk);
        #1 out_rdy = 1'b1;
      end
    join
    drain();

    // flush with three in flight plus one presented, under a stall
    send(MUL_LO, 64'h11, 64'h11, 6'd30, 64'h0, 6'b0, 0, 0);
    send(MUL_LO, 64'h22, 64'h22, 6'd31, 64'h0, 6'b0, 0, 0);
    send(MUL_LO, 64'h33, 64'h33, 6'd32, 64'h0, 6'b0, 0, 0);
    op = MUL_LO; a = 64'h44; b = 64'h44; tag = 6'd33;
    in_vld = 1'b1; flush = 1'b1; out_rdy = 1'b0;
    @(posedge clk);
    #1 in_vld = 1'b0; flush = 1'b0; out_rdy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("flush_out_vld", 64'(out_vld), 64'd0);
    end
    @(posedge clk);
    #1;
    send(MUL_LO, 64'h9, 64'h9, 6'd9, 64'h51, 6'b000000, 1, 1);
    drain();

    // one-cycle reset mid-stream
    send(MULH_UU, 64'h1234, 64'h5678, 6'd20, 64'h0, 6'b0, 0, 0);
    send(MULH_UU, 64'h4321, 64'h8765, 6'd21, 64'h0, 6'b0, 0, 0);
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_out_vld", 64'(out_vld), 64'd0);
    check("midrst_res", res, 64'd0);
    check("midrst_out_tag", 64'(out_tag), 64'd0);
    check("midrst_in_rdy", 64'(in_rdy), 64'd1);
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_stale", 64'(out_vld), 64'd0);
    end
    @(posedge clk);
    #1;
    send(MUL_HALF, 64'h3, 64'h5, 6'd22, 64'hF, 6'b000001, 1, 1);
    drain();

    repeat (8) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
